// File: rtl/pic_eeprom_ctrl_if.sv
// SFR bus from the core plus the synchronous data-EEPROM array port.
// slave = controller side, master = core/array side.
interface pic_eeprom_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic [1:0]        reg_sel;
    logic              reg_we;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] reg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  reg_sel, reg_we, reg_wdata, mem_rdata,
        output reg_rdata, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output reg_sel, reg_we, reg_wdata, mem_rdata,
        input  reg_rdata, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/pic_eeprom_ctrl.sv
// Data-EEPROM controller: EEDATA/EEADR/EECON1/EECON2 SFRs, 0x55/0xAA unlock, timed array writes.
// Optional EE_WRITE_VERIFY_EN adds a read-back compare after each write that sets WRERR on mismatch.
module pic_eeprom_ctrl #(
    parameter int                ADDR_W       = 6,
    parameter int                DATA_W       = 8,
    parameter int                WRITE_CYCLES = 16,
    parameter logic [DATA_W-1:0] UNLOCK1      = 8'h55,
    parameter logic [DATA_W-1:0] UNLOCK2      = 8'hAA
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    pic_eeprom_ctrl_if.slave      bus,
    output logic                  o_busy,
    output logic                  o_irq
);
    localparam int CNT_W = $clog2(WRITE_CYCLES + 1);

    typedef enum logic [1:0] {LK_IDLE, LK_1, LK_ARMED} lk_t;
    typedef enum logic [1:0] {M_IDLE, M_READ, M_WRITE, M_VERIFY} m_t;

    lk_t               r_lk_state, w_lk_next;
    m_t                r_m_state, w_m_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_eedata;
    logic [ADDR_W-1:0] r_eeadr;
    logic              r_rd, r_wr, r_wren, r_wrerr, r_eeif;

    logic w_busy, w_wr_eedata, w_wr_eeadr, w_wr_eecon1, w_wr_eecon2;
    logic w_wr_start, w_rd_start, w_rd_done, w_wr_done, w_verify_err;
    logic w_mem_we, w_mem_re;

    assign w_busy      = (r_m_state != M_IDLE);
    assign w_wr_eedata = bus.reg_we && (bus.reg_sel == 2'd0);
    assign w_wr_eeadr  = bus.reg_we && (bus.reg_sel == 2'd1);
    assign w_wr_eecon1 = bus.reg_we && (bus.reg_sel == 2'd2);
    assign w_wr_eecon2 = bus.reg_we && (bus.reg_sel == 2'd3);

    // WREN must already be set before the arming EECON1 write; WR takes priority over RD.
    assign w_wr_start = w_wr_eecon1 && bus.reg_wdata[1] && bus.reg_wdata[2] && r_wren
                        && (r_lk_state == LK_ARMED) && !w_busy;
    assign w_rd_start = w_wr_eecon1 && bus.reg_wdata[0] && !w_busy && !w_wr_start;
    assign w_rd_done  = (r_m_state == M_READ) && (r_cnt == CNT_W'(1));

`ifdef EE_WRITE_VERIFY_EN
    assign w_wr_done    = (r_m_state == M_VERIFY) && (r_cnt == CNT_W'(1));
    assign w_verify_err = w_wr_done && (bus.mem_rdata != r_eedata);
`else
    assign w_wr_done    = (r_m_state == M_WRITE) && (r_cnt == CNT_W'(WRITE_CYCLES));
    assign w_verify_err = 1'b0;
`endif

    // Unlock FSM
    always_ff @(posedge i_clk) begin
        if (!i_reset) r_lk_state <= LK_IDLE;
        else          r_lk_state <= w_lk_next;
    end

    always_comb begin
        w_lk_next = r_lk_state;
        if (bus.reg_we) begin
            if (r_lk_state == LK_ARMED)
                w_lk_next = LK_IDLE;
            else if (w_wr_eecon2 && bus.reg_wdata == UNLOCK1)
                w_lk_next = LK_1;
            else if (r_lk_state == LK_1 && w_wr_eecon2 && bus.reg_wdata == UNLOCK2)
                w_lk_next = LK_ARMED;
            else
                w_lk_next = LK_IDLE;
        end
    end

    // Main FSM; r_cnt restarts at 0 on every state change
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_m_state <= M_IDLE;
            r_cnt     <= '0;
        end else begin
            r_m_state <= w_m_next;
            r_cnt     <= (w_m_next != r_m_state) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_m_next = r_m_state;
        case (r_m_state)
            M_IDLE: begin
                if (w_wr_start)      w_m_next = M_WRITE;
                else if (w_rd_start) w_m_next = M_READ;
            end
            M_READ:   if (r_cnt == CNT_W'(1)) w_m_next = M_IDLE;
            M_WRITE: begin
                if (r_cnt == CNT_W'(WRITE_CYCLES)) begin
`ifdef EE_WRITE_VERIFY_EN
                    w_m_next = M_VERIFY;
`else
                    w_m_next = M_IDLE;
`endif
                end
            end
            M_VERIFY: if (r_cnt == CNT_W'(1)) w_m_next = M_IDLE;
            default:  w_m_next = M_IDLE;
        endcase
    end

    always_comb begin
        w_mem_we = (r_m_state == M_WRITE) && (r_cnt == '0);
        w_mem_re = ((r_m_state == M_READ) || (r_m_state == M_VERIFY)) && (r_cnt == '0);
    end

    // SFR state; EEADR/EEDATA frozen while busy so the array port stays stable
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_eedata <= '0;
            r_eeadr  <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_wren   <= 1'b0;
            r_eeif   <= 1'b0;
            r_wrerr  <= (r_m_state == M_WRITE) || (r_m_state == M_VERIFY);
        end else begin
            if (w_rd_done)                   r_eedata <= bus.mem_rdata;
            else if (w_wr_eedata && !w_busy) r_eedata <= bus.reg_wdata;
            if (w_wr_eeadr && !w_busy)       r_eeadr  <= bus.reg_wdata[ADDR_W-1:0];

            if (w_rd_start)     r_rd <= 1'b1;
            else if (w_rd_done) r_rd <= 1'b0;
            if (w_wr_start)     r_wr <= 1'b1;
            else if (w_wr_done) r_wr <= 1'b0;

            if (w_wr_eecon1) r_wren <= bus.reg_wdata[2];

            if (w_wr_done)                             r_eeif  <= 1'b1;
            else if (w_wr_eecon1 && !bus.reg_wdata[4]) r_eeif  <= 1'b0;
            if (w_verify_err)                          r_wrerr <= 1'b1;
            else if (w_wr_eecon1 && !bus.reg_wdata[3]) r_wrerr <= 1'b0;
        end
    end

    always_comb begin
        bus.reg_rdata = '0;
        case (bus.reg_sel)
            2'd0:    bus.reg_rdata = r_eedata;
            2'd1:    bus.reg_rdata = DATA_W'(r_eeadr);
            2'd2:    bus.reg_rdata = DATA_W'({r_eeif, r_wrerr, r_wren, r_wr, r_rd});
            default: bus.reg_rdata = '0;
        endcase
    end

    assign bus.mem_addr  = r_eeadr;
    assign bus.mem_wdata = r_eedata;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_re    = w_mem_re;
    assign o_busy        = w_busy;
    assign o_irq         = r_eeif;
endmodule

// File: doc/pic_eeprom_ctrl.md
Name: pic_eeprom_ctrl

Overview:
Data-EEPROM controller for the risc16f84 core. It exposes the EEDATA/EEADR/EECON1/EECON2 special-function registers to the core and enforces the 0x55/0xAA unlock sequence. It sequences reads and timed writes to an external synchronous data-EEPROM array and raises the EEIF interrupt when a write completes. It sits between the core's SFR bus and the EEPROM macro and is instantiated under dut_tb.

Parameters:
ADDR_W, 6, EEPROM address width (64 bytes)
DATA_W, 8, data width
WRITE_CYCLES, 16, clocks the array stays busy after the mem_we pulse
UNLOCK1, 8'h55, first EECON2 key
UNLOCK2, 8'hAA, second EECON2 key

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
reg_sel  in  2  SFR select: 0=EEDATA, 1=EEADR, 2=EECON1, 3=EECON2
reg_we  in  1  SFR write strobe, one cycle per write
reg_wdata  in  DATA_W  SFR write data
reg_rdata  out  DATA_W  SFR read data, combinational mux; EECON2 reads 0
mem_addr  out  ADDR_W  array address (= EEADR)
mem_wdata  out  DATA_W  array write data (= EEDATA)
mem_we  out  1  one-cycle write pulse
mem_re  out  1  one-cycle read pulse; mem_rdata valid the next cycle
mem_rdata  in  DATA_W  array read data
busy  out  1  write or read in progress
irq  out  1  equals EECON1.EEIF

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low.
- EECON1 bits: 0=RD, 1=WR, 2=WREN, 3=WRERR, 4=EEIF; bits 7:5 read 0.
- Reset values: EEDATA=0, EEADR=0, RD=WR=WREN=EEIF=0, mem_we=mem_re=busy=irq=0; both FSMs IDLE.
- WRERR at reset: set to 1 if reset is sampled while the main FSM is in WRITE, else cleared to 0.
- Unlock FSM (LK_IDLE, LK_1, LK_ARMED):
  - EECON2 write of UNLOCK1 → LK_1.
  - In LK_1, EECON2 write of UNLOCK2 → LK_ARMED.
  - Any other reg_we (other register or wrong key) → LK_IDLE.
  - In LK_ARMED, the next reg_we of any kind consumes the armed state → LK_IDLE.
- Main FSM (M_IDLE, M_READ, M_WRITE):
  - RD: EECON1 write with bit0=1 in M_IDLE at cycle N → mem_re=1 in N+1 (M_READ). EEDATA ← mem_rdata and RD → 0 at the N+2 edge; busy high N+1..N+2.
  - WR start: requires all of: LK_ARMED, EECON1 write with bit1=1, bit2=1, and current WREN=1, and M_IDLE. Otherwise the WR bit stays 0.
  - Write sequence: mem_we=1 for exactly 1 cycle (cycle after the start write), then busy for WRITE_CYCLES further cycles. At completion, WR → 0 and EEIF → 1.
  - If RD and WR are both requested in the same write, WR wins when its start conditions hold; otherwise RD is serviced.
- While busy:
  - Writes to EEDATA/EEADR are ignored.
  - RD and WR requests are ignored.
  - WREN, WRERR and EEIF remain writable.
- Software access rules:
  - EEIF and WRERR are cleared by software writing 0 to the bit; writing 1 has no effect.
  - Hardware set beats a same-cycle software clear.
  - RD and WR cannot be cleared by software.
- mem_addr/mem_wdata are held stable while mem_we/mem_re are asserted.

Optional Feature:
EE_WRITE_VERIFY_EN
- Defined: after the WRITE_CYCLES count, FSM enters M_VERIFY. It issues one mem_re at EEADR and compares mem_rdata against EEDATA the next cycle; a mismatch sets WRERR. WR clears and EEIF sets after the compare. Completion latency is +2 cycles and busy covers M_VERIFY.
- Undefined: no verify state; WRERR is set only by the reset-abort rule.

Test Plan:
1. Reset: hold reset=0 for 4 clocks → all outputs 0, reg_rdata=0 for every reg_sel.
2. Read: EEADR=0x05, array[5]=0xA5, write EECON1=0x01 at cycle N → mem_re=1 and mem_addr=0x05 at N+1; EEDATA=0xA5 and RD=0 at N+2; no mem_we.
3. Unlocked write: EEADR=0x10, EEDATA=0x3C, EECON1=0x04, EECON2=0x55, EECON2=0xAA, EECON1=0x06 → single mem_we with addr 0x10, data 0x3C; busy for 17 cycles; then WR=0, EEIF=1, irq=1. Writing EECON1=0x04 then clears irq.
4. Broken sequence: EECON2=0x55, EEADR write, EECON2=0xAA, EECON1=0x06 → no mem_we, WR reads 0. Repeat with WREN=0 and a correct sequence → no mem_we.
5. Busy protection: during a write, write EEDATA=0xFF and EECON1=0x01 → EEDATA unchanged, no mem_re; same-cycle EEIF clear and completion → EEIF=1.
6. Reset mid-write: assert reset at busy cycle 5 → all registers reset, WRERR=1, no further mem_we. With EE_WRITE_VERIFY_EN and array write disabled (stuck 0x00), completion → WRERR=1, EEIF=1.
